left_shift_register: RTL and testbench

Sequenced left-shift register for the multiplier/divider datapath. It is the opposite-direction companion to the existing right shift register. It parallel-loads a WIDTH-bit word, then on a start handshake shifts left by a programmed count, one bit per enabled clock. It reports busy/done, the last bit shifted out, and a sticky overflow flag for lost ones.

---
 rtl/left_shift_register.sv | 106 ++++++++++
 tb/tb_left_shift_register.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/left_shift_register.sv
// left_shift_register
//   Sequenced left shifter for the multiplier/divider datapath. Parallel-loads
//   a WIDTH-bit word, then on a start handshake shifts left by a latched count,
//   one position per enabled clock. Reports busy/done, the last bit shifted out
//   of the MSB, and a sticky overflow flag for any 1 lost off the top.
//
//   Optional feature: define LEFT_SHIFT_ROTATE_EN to rotate left (the MSB is
//   fed back into the LSB) instead of inserting serial_in.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   enable       clock enable; low freezes every register
//   mode         1 = parallel load request, 0 = shift operation select
//   in           parallel load data
//   serial_in    bit inserted at the LSB on each shift
//   start        begin shift operation (IDLE with mode=0 only)
//   shift_count  number of positions to shift, latched on start
//   out          register contents
//   serial_out   last bit shifted out of the MSB
//   busy         high while shifting
//   done         one-enabled-cycle completion pulse
//   overflow     sticky; set when a 1 leaves the MSB
module left_shift_register #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [WIDTH-1:0]   in,
  input  logic               serial_in,
  input  logic               start,
  input  logic [COUNT_W-1:0] shift_count,
  output logic [WIDTH-1:0]   out,
  output logic               serial_out,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE_S} state_t;

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] count;
  logic               ins_bit;

`ifdef LEFT_SHIFT_ROTATE_EN
  assign ins_bit = out[WIDTH-1];
`else
  assign ins_bit = serial_in;
`endif

  // Load has priority over start in IDLE.
  wire load_req  = (state == IDLE) && mode;
  wire start_req = (state == IDLE) && !mode && start;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = (shift_count == '0) ? DONE_S : SHIFT;
      SHIFT:   if (count == COUNT_W'(1)) state_nxt = DONE_S;
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE_S);
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      serial_out <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
    end else if (enable) begin
      if (load_req) begin
        out        <= in;
        overflow   <= 1'b0;
        serial_out <= 1'b0;
      end else if (start_req) begin
        count    <= shift_count;
        overflow <= 1'b0;
      end else if (state == SHIFT) begin
        out        <= {out[WIDTH-2:0], ins_bit};
        serial_out <= out[WIDTH-1];
        overflow   <= overflow | out[WIDTH-1];
        count      <= count - COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_left_shift_register.sv
module tb_left_shift_register;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, enable, mode, serial_in, start;
  logic [W-1:0]  in;
  logic [CW-1:0] shift_count;
  logic [W-1:0]  out;
  logic          serial_out, busy, done, overflow;

  int checks   = 0;
  int failures = 0;

  left_shift_register #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .in(in),
    .serial_in(serial_in), .start(start), .shift_count(shift_count),
    .out(out), .serial_out(serial_out), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the register sees a bit stream, MSB first. Logical shift: the
  // loaded word followed by an endless run of serial_in. Rotate: the loaded
  // word repeated forever. After N shifts the first N stream bits have left
  // through the MSB and out holds stream bits N..N+W-1.
  function automatic logic sbit(input logic [W-1:0] v, input int i, input logic si);
`ifdef LEFT_SHIFT_ROTATE_EN
    return v[W-1-(i%W)];
`else
    return (i < W) ? v[W-1-i] : si;
`endif
  endfunction

  task automatic model(input logic [W-1:0] v, input int n, input logic si,
                       output logic [W-1:0] eo, output logic eso, output logic eov);
    eov = 1'b0;
    for (int i = 0; i < n; i++) eov |= sbit(v, i, si);
    for (int j = 0; j < W; j++) eo[W-1-j] = sbit(v, n + j, si);
    eso = (n > 0) ? sbit(v, n - 1, si) : 1'b0;
  endtask

  // Load v, start an n-shift operation, optionally stall stall_len cycles once
  // stall_at enabled edges have passed, optionally drive load/start junk while
  // the operation is in progress.
  task automatic do_op(input string tag, input logic [W-1:0] v, input int n,
                       input logic si, input int stall_at, input int stall_len,
                       input bit junk);
    logic [W-1:0] eo;
    logic eso, eov;
    int edges, busy_n, stalls, ticks, guard;
    model(v, n, si, eo, eso, eov);

    mode = 1'b1; in = v; start = 1'b0; enable = 1'b1; tick;
    check({tag, ".load_out"}, 32'(out), 32'(v));
    check({tag, ".load_ovf"}, 32'(overflow), 0);

    mode = 1'b0; start = 1'b1; shift_count = CW'(n); serial_in = si; tick;
    edges = 1; ticks = 1; stalls = 0; start = 1'b0;
    busy_n = busy ? 1 : 0;
    guard = 0;
    while (!done && guard < 200) begin
      guard++;
      if (junk) begin mode = 1'b1; in = 16'hFFFF; start = 1'b1; end
      if (edges == stall_at && stalls < stall_len) begin enable = 1'b0; stalls++; end
      else enable = 1'b1;
      tick; ticks++;
      if (enable) begin edges++; if (busy) busy_n++; end
    end
    mode = 1'b0; start = 1'b0;
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".latency"}, 32'(edges), (n == 0) ? 1 : n + 1);
    check({tag, ".ticks"}, 32'(ticks), ((n == 0) ? 1 : n + 1) + stalls);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(n));
    check({tag, ".out"}, 32'(out), 32'(eo));
    check({tag, ".serial_out"}, 32'(serial_out), 32'(eso));
    check({tag, ".overflow"}, 32'(overflow), 32'(eov));

    // done holds across a stall, then drops after one enabled edge.
    enable = 1'b0; tick;
    check({tag, ".done_stall"}, 32'(done), 1);
    enable = 1'b1; tick;
    check({tag, ".done_drop"}, 32'({done, busy}), 0);
    check({tag, ".out_hold"}, 32'(out), 32'(eo));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; in = '0; serial_in = 1'b0;
    start = 1'b0; shift_count = '0;
    tick;
    check("reset", 32'({out, serial_out, busy, done, overflow}), 0);
    reset = 1'b0; tick;

    do_op("plan_9696", 16'b1001011010010110, 4, 1'b0, 0, 0, 1'b0);
    do_op("plan_cnt0", 16'h0001, 0, 1'b0, 0, 0, 1'b0);
    do_op("plan_cnt20", 16'h00FF, 20, 1'b1, 0, 0, 1'b0);
    do_op("plan_stall", 16'h1234, 8, 1'b0, 4, 3, 1'b1);
    do_op("plan_8001", 16'h8001, 1, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a shift.
    mode = 1'b1; in = 16'hA5A5; enable = 1'b1; tick;
    mode = 1'b0; start = 1'b1; shift_count = CW'(8); serial_in = 1'b1; tick;
    start = 1'b0; tick; tick;
    check("rst_mid.busy_before", 32'(busy), 1);
    #2 reset = 1'b1; #1;
    check("rst_mid.async", 32'({out, serial_out, busy, done, overflow}), 0);
    tick;
    check("rst_mid.no_done", 32'(done), 0);
    reset = 1'b0;
    mode = 1'b1; in = 16'h5A5A; tick;
    check("rst_mid.load_after", 32'(out), 32'h5A5A);
    check("rst_mid.idle", 32'({busy, done}), 0);

    for (int r = 0; r < 12; r++) begin
      do_op($sformatf("rand%0d", r), W'($urandom), int'($urandom_range(0, 25)),
            1'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
